// File: rtl/ram_wr_scheduler_if.sv
// Bundle for the write scheduler: four client request channels plus the
// registered memory write port and the busy flag.
interface ram_wr_scheduler_if #(
  parameter int BLOCKSIZE = 10,
  parameter int DATA_W    = 32
);
  logic                c0_valid, c1_valid, c2_valid, c3_valid;
  logic                c0_ready, c1_ready, c2_ready, c3_ready;
  logic [BLOCKSIZE:0]  c0_addr,  c1_addr,  c2_addr,  c3_addr;
  logic [DATA_W-1:0]   c0_data,  c1_data,  c2_data,  c3_data;
  logic [BLOCKSIZE:0]  w_addr_1;
  logic [DATA_W-1:0]   w_din_1;
  logic                w_enb_1;
  logic                busy;

  modport master (
    output c0_valid, c1_valid, c2_valid, c3_valid,
    output c0_addr,  c1_addr,  c2_addr,  c3_addr,
    output c0_data,  c1_data,  c2_data,  c3_data,
    input  c0_ready, c1_ready, c2_ready, c3_ready,
    input  w_addr_1, w_din_1, w_enb_1, busy
  );

  modport slave (
    input  c0_valid, c1_valid, c2_valid, c3_valid,
    input  c0_addr,  c1_addr,  c2_addr,  c3_addr,
    input  c0_data,  c1_data,  c2_data,  c3_data,
    output c0_ready, c1_ready, c2_ready, c3_ready,
    output w_addr_1, w_din_1, w_enb_1, busy
  );
endinterface

// File: rtl/ram_wr_scheduler.sv
// Four-client round-robin write scheduler feeding the memory's single write port.
// Define WR_PRIO_EN to give client 0 strict priority over round-robin clients 1..3.
module ram_wr_scheduler #(
  parameter int BLOCKSIZE  = 10,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_wr_scheduler_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

`ifdef WR_PRIO_EN
  localparam logic [3:0] RR_MASK = 4'b1110;
`else
  localparam logic [3:0] RR_MASK = 4'b1111;
`endif

  typedef struct packed {
    logic [BLOCKSIZE:0] addr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic   [3:0]                 c_valid;
  entry_t                       c_entry [4];
  logic   [3:0]                 ready, nonempty, push, pop;
  logic   [3:0][CW-1:0]         cnt_q, cnt_d;
  logic   [3:0][DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic   [1:0]                 ptr_q, ptr_d;
  logic   [1:0]                 scan, rr_idx, grant_idx;
  logic                         rr_valid, grant_valid;
  entry_t                       fifo_mem [4][DEPTH];
  entry_t                       head;
  entry_t                       w_entry_q, w_entry_d;
  logic                         w_enb_q, w_enb_d;

  assign c_valid    = {bus.c3_valid, bus.c2_valid, bus.c1_valid, bus.c0_valid};
  assign c_entry[0] = {bus.c0_addr, bus.c0_data};
  assign c_entry[1] = {bus.c1_addr, bus.c1_data};
  assign c_entry[2] = {bus.c2_addr, bus.c2_data};
  assign c_entry[3] = {bus.c3_addr, bus.c3_data};

  // Ready and non-empty come only from registered counts, never from valid.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ready[n]    = (cnt_q[n] != CW'(DEPTH));
      nonempty[n] = (cnt_q[n] != '0);
    end
  end

  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = ptr_q;
    scan     = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      scan = ptr_q + 2'(i);
      if (!rr_valid && nonempty[scan] && RR_MASK[scan]) begin
        rr_valid = 1'b1;
        rr_idx   = scan;
      end
    end
  end

  always_comb begin
`ifdef WR_PRIO_EN
    if (nonempty[0]) begin
      grant_valid = 1'b1;
      grant_idx   = 2'd0;
      ptr_d       = ptr_q;
    end else begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
      ptr_d       = rr_valid ? rr_idx : ptr_q;
    end
`else
    grant_valid = rr_valid;
    grant_idx   = rr_idx;
    ptr_d       = rr_valid ? rr_idx : ptr_q;
`endif
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      push[n]     = c_valid[n] && ready[n];
      pop[n]      = grant_valid && (grant_idx == 2'(n));
      cnt_d[n]    = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
      wr_ptr_d[n] = wr_ptr_q[n] + DEPTH_LOG2'(push[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + DEPTH_LOG2'(pop[n]);
    end
  end

  assign head      = fifo_mem[grant_idx][rd_ptr_q[grant_idx]];
  assign w_enb_d   = grant_valid;
  assign w_entry_d = grant_valid ? head : w_entry_q;

  // NOTE: FIFO storage has no reset; the counts and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) fifo_mem[n][wr_ptr_q[n]] <= c_entry[n];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ptr_q     <= 2'd3;
      w_enb_q   <= 1'b0;
      w_entry_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ptr_q     <= ptr_d;
      w_enb_q   <= w_enb_d;
      w_entry_q <= w_entry_d;
    end
  end

  assign bus.c0_ready = ready[0];
  assign bus.c1_ready = ready[1];
  assign bus.c2_ready = ready[2];
  assign bus.c3_ready = ready[3];
  assign bus.w_addr_1 = w_entry_q.addr;
  assign bus.w_din_1  = w_entry_q.data;
  assign bus.w_enb_1  = w_enb_q;
  assign bus.busy     = (|nonempty) | w_enb_q;
endmodule
